pdnn_activation: RTL and testbench

Parametrised, multi-mode activation unit for the LVI-PDNN datapath. It sits between the accumulator bank and the state-update stage. It accepts an N-channel vector from the accumulators and applies one of four piecewise-linear activation functions per channel. The channels go through one shared compare/select datapath, one channel per clock. The result vector is presented with a valid/ready handshake. The active-low enable of the single-channel predecessor is kept as a global freeze.

---
 rtl/pdnn_activation.sv | 187 ++++++++++++++++++
 tb/tb_pdnn_activation.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pdnn_activation.sv
// Multi-mode piecewise-linear activation unit: accepts an N-channel vector, runs each
// channel through one shared clamp/ReLU/shift datapath (one channel per clock), returns the vector.
module pdnn_activation #(
  parameter int W     = 32,
  parameter int N     = 4,
  parameter int SHIFT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_n,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   lo,
  input  logic [W-1:0]   hi,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           cfg_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [N*W-1:0] r_data;
  logic [N*W-1:0] w_data_nxt;
  logic [N*W-1:0] r_out_data;
  logic [N*W-1:0] w_out_nxt;
  logic [1:0]     r_mode;
  logic [1:0]     w_mode_nxt;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   w_lo_nxt;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   w_hi_nxt;
  logic           r_cfg_err;
  logic           w_cfg_err_nxt;
  logic           w_last;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_f;

  // Lower-bound test wins over the upper one, so an inverted window still gives a fixed answer.
  function automatic logic [W-1:0] f_act(input logic [1:0] m, input logic [W-1:0] x,
                                         input logic [W-1:0] b_lo, input logic [W-1:0] b_hi);
    logic [W-1:0] y;
    case (m)
      2'd0: y = x;
      2'd1: begin
        if ($signed(x) < $signed(b_lo)) begin
          y = b_lo;
        end else if ($signed(x) > $signed(b_hi)) begin
          y = b_hi;
        end else begin
          y = x;
        end
      end
      2'd2: begin
        if (x[W-1]) begin
          y = {W{1'b0}};
        end else begin
          y = x;
        end
      end
      2'd3: y = W'($signed(x) >>> SHIFT);
      default: y = x;
    endcase
    return y;
  endfunction

  assign w_last = (r_cnt == CW'(N - 1));

  // Channel select feeding the shared activation datapath.
  always_comb begin
    w_x = r_data[W-1:0];
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) begin
        w_x = r_data[k*W +: W];
      end else begin
        w_x = w_x;
      end
    end
  end

  assign w_f = f_act(r_mode, w_x, r_lo, r_hi);

  // Next-state and datapath update; the register stage applies it only when enabled.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_mode_nxt    = r_mode;
    w_lo_nxt      = r_lo;
    w_hi_nxt      = r_hi;
    w_cfg_err_nxt = r_cfg_err;
    w_out_nxt     = r_out_data;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_data_nxt  = in_data;
          w_mode_nxt  = mode;
          w_lo_nxt    = lo;
          w_hi_nxt    = hi;
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_RUN;
          if ((mode == 2'd1) && ($signed(lo) > $signed(hi))) begin
            w_cfg_err_nxt = 1'b1;
          end else begin
            w_cfg_err_nxt = r_cfg_err;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        for (int k = 0; k < N; k++) begin
          if (r_cnt == CW'(k)) begin
            w_out_nxt[k*W +: W] = w_f;
          end else begin
            w_out_nxt[k*W +: W] = r_out_data[k*W +: W];
          end
        end
        if (w_last) begin
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers; en_n high freezes everything, including the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_data     <= {(N*W){1'b0}};
      r_out_data <= {(N*W){1'b0}};
      r_mode     <= 2'd0;
      r_lo       <= {W{1'b0}};
      r_hi       <= {W{1'b0}};
      r_cfg_err  <= 1'b0;
    end else if (!en_n) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_out_data <= w_out_nxt;
      r_mode     <= w_mode_nxt;
      r_lo       <= w_lo_nxt;
      r_hi       <= w_hi_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
    end else begin
      r_state    <= r_state;
      r_cnt      <= r_cnt;
      r_data     <= r_data;
      r_out_data <= r_out_data;
      r_mode     <= r_mode;
      r_lo       <= r_lo;
      r_hi       <= r_hi;
      r_cfg_err  <= r_cfg_err;
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !en_n;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pdnn_activation.sv
// Directed bench for pdnn_activation: table of whole-vector transactions plus
// hand-written freeze, back-pressure and asynchronous-reset sequences.
module tb_pdnn_activation;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           en_n;
  logic [1:0]     mode;
  logic [W-1:0]   lo;
  logic [W-1:0]   hi;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           cfg_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]     mode;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic [N*W-1:0] din;
    logic [N*W-1:0] dout;
    logic           cfg;
  } vec_t;

  vec_t tbl[7];

  pdnn_activation #(.W(W), .N(N), .SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .lo(lo), .hi(hi),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack4(input int c3, input int c2, input int c1, input int c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [W-1:0] l, input logic [W-1:0] h,
                       input logic [N*W-1:0] d);
    in_valid = 1'b1;
    mode     = m;
    lo       = l;
    hi       = h;
    in_data  = d;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    mode     = ~mode;
    lo       = ~lo;
    hi       = ~hi;
    in_data  = ~in_data;
  endtask

  // One full transaction from IDLE, checking exact latency, data, cfg_err and handoff.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
    drive(v.mode, v.lo, v.hi, v.din);
    cyc();
    scramble();
    repeat (N - 1) cyc();
    chk($sformatf("v%0d_early_valid", idx), out_valid, 0);
    cyc();
    chk($sformatf("v%0d_out_valid", idx), out_valid, 1);
    chk($sformatf("v%0d_out_data", idx), out_data, v.dout);
    chk($sformatf("v%0d_cfg_err", idx), cfg_err, v.cfg);
    chk($sformatf("v%0d_busy", idx), in_ready, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk($sformatf("v%0d_valid_drop", idx), out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'd0, 32'd0, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 1'b0};
    tbl[1] = '{2'd1, -32'sd100, 32'sd100, pack4(500, -500, 42, 100), pack4(100, -100, 42, 100), 1'b0};
    tbl[2] = '{2'd2, 32'd0, 32'd0, pack4(32'h8000_0000, -1, 0, 7), pack4(0, 0, 0, 7), 1'b0};
    tbl[3] = '{2'd3, 32'd0, 32'd0, pack4(-3, 3, -1, 32'h7FFF_FFFF), pack4(-2, 1, -1, 32'h3FFF_FFFF), 1'b0};
    tbl[4] = '{2'd1, -32'sd5, 32'sd5, pack4(-5, 5, -6, 6), pack4(-5, 5, -5, 5), 1'b0};
    tbl[5] = '{2'd1, 32'sd10, 32'sd5, pack4(0, 7, 20, 10), pack4(10, 10, 5, 5), 1'b1};
    tbl[6] = '{2'd0, 32'd0, 32'd0, pack4(32'hAAAA_5555, -9, 32'h1234_5678, 0),
               pack4(32'hAAAA_5555, -9, 32'h1234_5678, 0), 1'b1};

    rst_n = 1'b0; en_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = 2'd0; lo = '0; hi = '0; in_data = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_in_ready", in_ready, 1);

    // Freeze for three edges after channel 1 has been written.
    drive(2'd3, 32'd0, 32'd0, pack4(-8, 9, 100, -1));
    cyc();
    scramble();
    cyc();
    cyc();
    en_n = 1'b1;
    chk("frz_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("frz_data_%0d", i), out_data, pack4(0, 0, 50, -1));
      chk($sformatf("frz_valid_%0d", i), out_valid, 0);
    end
    en_n = 1'b0;
    cyc();
    chk("frz_resume_data", out_data, pack4(0, 4, 50, -1));
    chk("frz_resume_valid", out_valid, 0);
    cyc();
    chk("frz_late_valid", out_valid, 1);
    chk("frz_final_data", out_data, pack4(-4, 4, 50, -1));
    en_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("frz_done_hold", out_valid, 1);
    en_n = 1'b0;
    cyc();
    out_ready = 1'b0;
    chk("frz_done_xfer", out_valid, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Back-pressure in DONE with a new vector already waiting.
    drive(2'd2, 32'd0, 32'd0, pack4(-5, 5, -6, 6));
    cyc();
    drive(2'd0, 32'd0, 32'd0, pack4(11, 22, 33, 44));
    repeat (N) cyc();
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
      chk($sformatf("bp_hold_data_%0d", i), out_data, pack4(0, 5, 0, 6));
      chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_xfer_valid", out_valid, 0);
    chk("bp_xfer_ready", in_ready, 1);
    cyc();
    scramble();
    chk("bp_accepted", in_ready, 0);
    repeat (N - 1) cyc();
    chk("bp2_early_valid", out_valid, 0);
    cyc();
    chk("bp2_valid", out_valid, 1);
    chk("bp2_data", out_data, pack4(11, 22, 33, 44));
    chk("bp2_cfg_sticky", cfg_err, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of RUN.
    drive(2'd0, 32'd0, 32'd0, pack4(1, 1, 1, 1));
    cyc();
    scramble();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run_data", out_data, 0);
    chk("arst_run_cfg", cfg_err, 0);
    chk("arst_run_valid", out_valid, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("arst_run_ready", in_ready, 1);

    // Asynchronous reset while holding a result in DONE.
    drive(2'd2, 32'd0, 32'd0, pack4(3, -3, 3, -3));
    cyc();
    scramble();
    repeat (N) cyc();
    chk("arst_done_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_valid", out_valid, 0);
    chk("arst_done_data", out_data, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("arst_done_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
